// File: rtl/cordic_polar_demod.sv
// cordic_polar_demod
//   Post-processing for a CORDIC translate (vectoring) stage. It turns the
//   phase stream into an FM discriminator output and the magnitude stream
//   into block-averaged mean and peak values.
//
//   Parameters
//     ITERATIONS  CORDIC iteration count; theta and freq are ITERATIONS+1 bits
//     DATA_WIDTH  CORDIC input width; r and the magnitude outputs are DATA_WIDTH+2 bits
//     AVG_LOG2    the magnitude block length is 2**AVG_LOG2 samples
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     sclr         synchronous clear of the demodulator state
//     s_valid      theta/r are valid this cycle (no backpressure)
//     theta        unsigned phase, 2**(ITERATIONS+1) LSB = 2*pi
//     r            signed magnitude; negative values are clamped to 0
//     squelch_thr  unsigned magnitude squelch threshold (quasi-static)
//     freq_valid   one-cycle strobe qualifying freq/squelched
//     freq         signed phase difference, wraps modulo 2*pi
//     squelched    the current freq sample was forced to 0 by the squelch
//     mag_valid    one-cycle strobe qualifying mag_avg/mag_peak
//     mag_avg      truncated block mean of the clamped magnitude
//     mag_peak     block maximum of the clamped magnitude
module cordic_polar_demod #(
  parameter int unsigned ITERATIONS = 7,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned AVG_LOG2   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclr,
  input  logic                    s_valid,
  input  logic [ITERATIONS:0]     theta,
  input  logic [DATA_WIDTH+1:0]   r,
  input  logic [DATA_WIDTH+1:0]   squelch_thr,
  output logic                    freq_valid,
  output logic [ITERATIONS:0]     freq,
  output logic                    squelched,
  output logic                    mag_valid,
  output logic [DATA_WIDTH+1:0]   mag_avg,
  output logic [DATA_WIDTH+1:0]   mag_peak
);

  localparam int unsigned TW = ITERATIONS + 1;
  localparam int unsigned RW = DATA_WIDTH + 2;
  localparam int unsigned AW = RW + AVG_LOG2;

  typedef enum logic {WAIT_FIRST, RUN} state_t;

  state_t              state;
  logic [TW-1:0]       theta_prev;
  logic [AW-1:0]       acc;
  logic [RW-1:0]       peak;
  logic [AVG_LOG2-1:0] cnt;

  logic [RW-1:0]       r_c;
  logic [TW-1:0]       theta_diff;
  logic [AW-1:0]       acc_sum;
  logic [RW-1:0]       peak_next;
  logic                below_thr;

  always_comb begin
    r_c        = r[RW-1] ? '0 : r;
    // Modular subtraction gives the natural +/-pi wrap when read as signed.
    theta_diff = theta - theta_prev;
    // The accumulator has AVG_LOG2 guard bits, so a full block cannot overflow.
    acc_sum    = acc + {{AVG_LOG2{1'b0}}, r_c};
    peak_next  = (r_c > peak) ? r_c : peak;
    below_thr  = (r_c < squelch_thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FIRST;
      theta_prev <= '0;
      acc        <= '0;
      peak       <= '0;
      cnt        <= '0;
      freq_valid <= 1'b0;
      freq       <= '0;
      squelched  <= 1'b0;
      mag_valid  <= 1'b0;
      mag_avg    <= '0;
      mag_peak   <= '0;
    end else begin
      freq_valid <= 1'b0;
      mag_valid  <= 1'b0;
      if (sclr) begin
        // A sample arriving with sclr is dropped; data outputs keep their value.
        state      <= WAIT_FIRST;
        theta_prev <= '0;
        acc        <= '0;
        peak       <= '0;
        cnt        <= '0;
      end else if (s_valid) begin
        theta_prev <= theta;
        case (state)
          WAIT_FIRST: state <= RUN;
          RUN: begin
            freq_valid <= 1'b1;
            squelched  <= below_thr;
            freq       <= below_thr ? '0 : theta_diff;
          end
          default: state <= WAIT_FIRST;
        endcase

        if (cnt == '1) begin
          mag_valid <= 1'b1;
          mag_avg   <= acc_sum[AW-1:AVG_LOG2];
          mag_peak  <= peak_next;
          acc       <= '0;
          peak      <= '0;
        end else begin
          acc  <= acc_sum;
          peak <= peak_next;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_polar_demod.sv
module tb_cordic_polar_demod;

  logic        clk;
  logic        rst_n;
  logic        sclr;
  logic        s_valid;
  logic [7:0]  theta;
  logic [17:0] r;
  logic [17:0] squelch_thr;
  logic        freq_valid;
  logic [7:0]  freq;
  logic        squelched;
  logic        mag_valid;
  logic [17:0] mag_avg;
  logic [17:0] mag_peak;

  int checks;
  int failures;

  cordic_polar_demod #(
    .ITERATIONS(7),
    .DATA_WIDTH(16),
    .AVG_LOG2(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclr(sclr),
    .s_valid(s_valid),
    .theta(theta),
    .r(r),
    .squelch_thr(squelch_thr),
    .freq_valid(freq_valid),
    .freq(freq),
    .squelched(squelched),
    .mag_valid(mag_valid),
    .mag_avg(mag_avg),
    .mag_peak(mag_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sclr;
    logic        valid;
    logic [7:0]  theta;
    logic [17:0] r;
    logic [17:0] thr;
    logic        fv;
    logic [7:0]  freq;
    logic        sq;
    logic        mv;
    logic [17:0] avg;
    logic [17:0] peak;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic v, input logic [7:0] th,
                     input logic [17:0] rr, input logic [17:0] thr,
                     input logic fv, input logic [7:0] fq, input logic sq,
                     input logic mv, input logic [17:0] avg, input logic [17:0] pk);
    vec_t e;
    e.sclr = s; e.valid = v; e.theta = th; e.r = rr; e.thr = thr;
    e.fv = fv; e.freq = fq; e.sq = sq; e.mv = mv; e.avg = avg; e.peak = pk;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, clock it in, and compare outputs just after the edge.
  task automatic apply(input vec_t e, input string tag);
    sclr        = e.sclr;
    s_valid     = e.valid;
    theta       = e.theta;
    r           = e.r;
    squelch_thr = e.thr;
    @(posedge clk);
    #1;
    chk({tag, " freq_valid"}, {31'd0, freq_valid}, {31'd0, e.fv});
    chk({tag, " freq"},       {24'd0, freq},       {24'd0, e.freq});
    chk({tag, " squelched"},  {31'd0, squelched},  {31'd0, e.sq});
    chk({tag, " mag_valid"},  {31'd0, mag_valid},  {31'd0, e.mv});
    chk({tag, " mag_avg"},    {14'd0, mag_avg},    {14'd0, e.avg});
    chk({tag, " mag_peak"},   {14'd0, mag_peak},   {14'd0, e.peak});
  endtask

  initial begin
    vec_t e;
    checks = 0;
    failures = 0;

    // Consecutive phase differences, +4 then -8.
    add(0,1,8'h10,18'd1000,0, 0,8'h00,0, 0,0,0);
    add(0,1,8'h14,18'd1000,0, 1,8'h04,0, 0,0,0);
    add(0,1,8'h0C,18'd1000,0, 1,8'hF8,0, 0,0,0);
    add(0,0,8'h0C,18'd1000,0, 0,8'hF8,0, 0,0,0);
    add(1,0,8'h00,18'd0,   0, 0,8'hF8,0, 0,0,0);
    // Wrap-around: FE->02 is +4; 40->C0 is -128.
    add(0,1,8'hFE,18'd1000,0, 0,8'hF8,0, 0,0,0);
    add(0,1,8'h02,18'd1000,0, 1,8'h04,0, 0,0,0);
    add(1,0,8'h00,18'd0,   0, 0,8'h04,0, 0,0,0);
    add(0,1,8'h40,18'd1000,0, 0,8'h04,0, 0,0,0);
    add(0,1,8'hC0,18'd1000,0, 1,8'h80,0, 0,0,0);
    // sclr with s_valid discards the sample; the next one is a first sample.
    add(1,1,8'h55,18'd1000,0, 0,8'h80,0, 0,0,0);
    add(0,1,8'h10,18'd1000,0, 0,8'h80,0, 0,0,0);
    add(1,0,8'h00,18'd0,   0, 0,8'h80,0, 0,0,0);
    // Squelch, thr=100: none in WAIT_FIRST, r==thr is not squelched.
    add(0,1,8'h20,18'd50, 100, 0,8'h80,0, 0,0,0);
    add(0,1,8'h30,18'd150,100, 1,8'h10,0, 0,0,0);
    add(0,1,8'h38,18'd50, 100, 1,8'h00,1, 0,0,0);
    add(0,1,8'h3B,18'd150,100, 1,8'h03,0, 0,0,0);
    add(0,1,8'h40,18'd100,100, 1,8'h05,0, 0,0,0);
    add(0,0,8'h40,18'd100,100, 0,8'h05,0, 0,0,0);
    add(1,0,8'h00,18'd0,  0,   0,8'h05,0, 0,0,0);
    // Block 1: r = 0..15 -> avg 7, peak 15.
    for (int i = 0; i < 16; i++)
      add(0,1,8'h00,18'(i),0, (i > 0),(i == 0) ? 8'h05 : 8'h00,0,
          (i == 15),(i == 15) ? 18'd7 : 18'd0,(i == 15) ? 18'd15 : 18'd0);
    // Block 2: 32s with one -5 and an idle gap -> avg 30, peak 32.
    for (int i = 0; i < 16; i++) begin
      add(0,1,8'h00,(i == 3) ? 18'h3FFFB : 18'd32,0, 1,8'h00,0,
          (i == 15),(i == 15) ? 18'd30 : 18'd7,(i == 15) ? 18'd32 : 18'd15);
      if (i == 7)
        add(0,0,8'h00,18'd32,0, 0,8'h00,0, 0,18'd7,18'd15);
    end
    // Partial block, then sclr together with s_valid, then a new partial block.
    add(1,0,8'h00,18'd0,0, 0,8'h00,0, 0,18'd30,18'd32);
    for (int i = 0; i < 5; i++)
      add(0,1,8'h00,18'd100,0, (i > 0),8'h00,0, 0,18'd30,18'd32);
    add(1,1,8'h00,18'd100,0, 0,8'h00,0, 0,18'd30,18'd32);
    for (int i = 0; i < 10; i++)
      add(0,1,8'h00,18'd100,0, (i > 0),8'h00,0, 0,18'd30,18'd32);

    // Reset state.
    rst_n = 1'b0; sclr = 1'b0; s_valid = 1'b0; theta = '0; r = '0; squelch_thr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset freq_valid", {31'd0, freq_valid}, 32'd0);
    chk("reset freq",       {24'd0, freq},       32'd0);
    chk("reset squelched",  {31'd0, squelched},  32'd0);
    chk("reset mag_valid",  {31'd0, mag_valid},  32'd0);
    chk("reset mag_avg",    {14'd0, mag_avg},    32'd0);
    chk("reset mag_peak",   {14'd0, mag_peak},   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-block: outputs clear without a clock edge.
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst freq",     {24'd0, freq},     32'd0);
    chk("midrst mag_avg",  {14'd0, mag_avg},  32'd0);
    chk("midrst mag_peak", {14'd0, mag_peak}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A full fresh block is needed; peak mid-block, truncating mean 1160/16.
    for (int i = 0; i < 16; i++) begin
      e.sclr = 0; e.valid = 1; e.theta = 8'(i * 3); e.thr = 0;
      e.r = (i == 5) ? 18'd200 : 18'd64;
      e.fv = (i > 0); e.freq = (i > 0) ? 8'h03 : 8'h00; e.sq = 0;
      e.mv = (i == 15);
      e.avg = (i == 15) ? 18'd72 : 18'd0;
      e.peak = (i == 15) ? 18'd200 : 18'd0;
      apply(e, $sformatf("post_rst%0d", i));
    end
    e.valid = 0; e.fv = 0; e.mv = 0;
    apply(e, "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_polar_demod.md
CORDIC_POLAR_DEMOD -- requirements
Module: cordic_polar_demod

Interface
REQ-001 Parameter ITERATIONS, default 7: CORDIC iteration count; the theta width is ITERATIONS+1.
REQ-002 Parameter DATA_WIDTH, default 16: CORDIC input width; the r width is DATA_WIDTH+2.
REQ-003 Parameter AVG_LOG2, default 4: the magnitude block length is 2^AVG_LOG2 samples.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port sclr, input, 1 bit: synchronous clear of the demodulator state.
REQ-007 Port s_valid, input, 1 bit: theta and r are valid this cycle.
REQ-008 Port theta, input, ITERATIONS+1 bits, unsigned: phase from the CORDIC translate stage; 2^(ITERATIONS+1) LSB equals 2*pi.
REQ-009 Port r, input, DATA_WIDTH+2 bits, signed: magnitude from the CORDIC translate stage.
REQ-010 Port squelch_thr, input, DATA_WIDTH+2 bits, unsigned: magnitude squelch threshold; quasi-static.
REQ-011 Port freq_valid, output, 1 bit: single-cycle strobe for freq.
REQ-012 Port freq, output, ITERATIONS+1 bits, signed: phase difference (FM discriminator output).
REQ-013 Port squelched, output, 1 bit: the current freq sample was squelched; qualified by freq_valid.
REQ-014 Port mag_valid, output, 1 bit: single-cycle strobe for mag_avg and mag_peak.
REQ-015 Port mag_avg, output, DATA_WIDTH+2 bits, unsigned: block mean of r.
REQ-016 Port mag_peak, output, DATA_WIDTH+2 bits, unsigned: block maximum of r.

Function
REQ-017 Input r SHALL be treated as unsigned after clamping negative values to 0; "r_c" below denotes the clamped value.
REQ-018 Phase state machine SHALL have two states, WAIT_FIRST and RUN, entered as WAIT_FIRST after reset or sclr.
REQ-019 In WAIT_FIRST, a valid sample SHALL store theta into theta_prev, move to RUN, and leave freq_valid low.
REQ-020 In RUN, each valid sample SHALL produce freq_valid=1 on the next rising edge (1-cycle latency), with freq = (theta - theta_prev) mod 2^(ITERATIONS+1) read as two's complement, and SHALL update theta_prev.
REQ-021 Wrap-around SHALL be natural modular: prev=0xFE, cur=0x02 gives +4; prev=0x02, cur=0xFE gives -4; a difference of exactly 0x80 gives -128.
REQ-022 If r_c < squelch_thr in RUN, freq SHALL be 0 and squelched=1, freq_valid SHALL still assert, and theta_prev SHALL still update; otherwise squelched=0.
REQ-023 The squelch test SHALL NOT apply in WAIT_FIRST.
REQ-024 When s_valid=0, all state, counters and outputs SHALL hold, except the strobes, which deassert.
REQ-025 Averager: a counter of width AVG_LOG2 SHALL count valid samples; the accumulator SHALL be DATA_WIDTH+2+AVG_LOG2 bits and never overflow.
REQ-026 On a valid sample with counter = 2^AVG_LOG2-1, the next edge SHALL set mag_avg = (acc + r_c) >> AVG_LOG2 (truncating), set mag_peak = max(block peak, r_c), pulse mag_valid for one cycle, and clear acc, peak and the counter (wrap to 0).
REQ-027 The averager SHALL run independently of the phase state and of squelch.
REQ-028 Outputs freq, mag_avg and mag_peak SHALL hold their last value between strobes.
REQ-029 sclr SHALL return the block to WAIT_FIRST, clear acc, peak, counter and theta_prev, and deassert the strobes; freq, squelched, mag_avg and mag_peak SHALL hold.
REQ-030 If sclr and s_valid are asserted in the same cycle, sclr SHALL win and the sample SHALL be discarded.
REQ-031 The block SHALL have no backpressure; one sample per cycle SHALL be sustained.

Reset
REQ-032 While rst_n=0, all registers and outputs SHALL be 0 and the state SHALL be WAIT_FIRST, asynchronously.
REQ-033 A reset asserted mid-block SHALL discard the partial average; after release, the first valid sample SHALL produce no freq_valid.

Verification
REQ-034 Scenario: theta sequence 0x10, 0x14, 0x0C on consecutive cycles (r=1000, thr=0) -> freq_valid on the 2nd and 3rd outputs only, freq = +4 then -8, each 1 cycle after its input.
REQ-035 Scenario: theta 0xFE then 0x02, then theta 0x40 then 0xC0 (fresh sequences after sclr) -> freq +4, then -128.
REQ-036 Scenario: 16 valid samples, r = 0..15 (AVG_LOG2=4) -> exactly one mag_valid, 1 cycle after the 16th sample, with mag_avg=7 and mag_peak=15; next block starts from acc=0.
REQ-037 Scenario: r=-5 in a 16-sample block of otherwise 32 -> treated as 0; mag_avg=30, mag_peak=32.
REQ-038 Scenario: thr=100; samples r=150, 50, 150 with distinct theta -> 2nd output freq=0 with squelched=1; 3rd output uses the squelched sample's theta as prev.
REQ-039 Scenario: sclr asserted together with s_valid after 5 samples, then rst_n pulsed low mid-block -> no strobe from the discarded sample, and the averager needs a full 16 new samples before mag_valid.
